// File: rtl/sensor_temp_serial.sv
// ============================================================================
// Module   : sensor_temp_serial
// Purpose  : ADC0831-style serial reader producing a 5-bit temperature sample.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sensor_temp_serial #(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_GAP = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en_m1,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [4:0] temperatura,
    output logic       lect,
    output logic       err
);

    localparam int               DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int               GAP_W       = $clog2(SAMPLE_GAP + 1);
    localparam logic [DIV_W-1:0] C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST  = GAP_W'(SAMPLE_GAP - 1);
    // 17 SCLK half-periods: 9 high phases interleaved with 8 low phases
    localparam logic [4:0]       C_HALF_LAST = 5'd16;
    localparam logic [7:0]       C_CODE_OPEN = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [4:0]       r_half;
    logic [4:0]       w_half_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [7:0]       r_sr;
    logic             r_cs_n;
    logic             r_sclk;
    logic             r_lect;
    logic             r_err;
    logic [4:0]       r_temp;
    logic             w_div_end;
    logic             w_shift_en;
    logic             w_load;

    assign w_div_end = (r_div == C_DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = '0;
        w_half_nxt  = r_half;
        w_gap_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                w_half_nxt = '0;
                if (en_m1) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_half_nxt = '0;
                w_div_nxt  = w_div_end ? '0 : r_div + DIV_W'(1);
                if (w_div_end) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_div_nxt = w_div_end ? '0 : r_div + DIV_W'(1);
                if (w_div_end) begin
                    if (r_half == C_HALF_LAST) begin
                        w_half_nxt  = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_half_nxt = r_half + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                w_half_nxt  = '0;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                w_half_nxt = '0;
                if (r_gap == C_GAP_LAST) begin
                    w_state_nxt = en_m1 ? ST_START : ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_half_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Edges 2..9 are the transitions into even half-periods >= 2
    assign w_shift_en = (r_state == ST_SHIFT) && w_div_end && r_half[0];
    assign w_load     = (r_state == ST_SHIFT) && (w_state_nxt == ST_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_half  <= '0;
            r_gap   <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_lect  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_half  <= w_half_nxt;
            r_gap   <= w_gap_nxt;
            r_cs_n  <= !((w_state_nxt == ST_START) || (w_state_nxt == ST_SHIFT));
            r_sclk  <= (w_state_nxt == ST_SHIFT) && !w_half_nxt[0];
            r_lect  <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sr   <= '0;
            r_temp <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_sr <= {r_sr[6:0], adc_dout};
            end
            // An all-ones code means the sensor is absent; keep the old reading
            if (w_load) begin
                if (r_sr == C_CODE_OPEN) begin
                    r_err <= 1'b1;
                end else begin
                    r_temp <= r_sr[7:3];
                    r_err  <= 1'b0;
                end
            end
        end
    end

    assign adc_cs_n    = r_cs_n;
    assign adc_sclk    = r_sclk;
    assign lect        = r_lect;
    assign err         = r_err;
    assign temperatura = r_temp;

endmodule

`default_nettype wire

// File: tb/tb_sensor_temp_serial.sv
// ============================================================================
// Module   : tb_sensor_temp_serial
// Purpose  : Directed bench with ADC model and expected-result scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sensor_temp_serial;

    localparam int CLK_DIV    = 4;
    localparam int SAMPLE_GAP = 16;
    localparam int FRAME      = 18 * CLK_DIV;
    localparam int PERIOD     = FRAME + 1 + SAMPLE_GAP;

    logic       clock = 1'b0;
    logic       reset;
    logic       en_m1;
    logic       adc_dout;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [4:0] temperatura;
    logic       lect;
    logic       err;

    sensor_temp_serial #(
        .CLK_DIV    (CLK_DIV),
        .SAMPLE_GAP (SAMPLE_GAP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en_m1       (en_m1),
        .adc_dout    (adc_dout),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .temperatura (temperatura),
        .lect        (lect),
        .err         (err)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    int         cs_fall_cyc = 0;
    int         cs_falls = 0;
    int         last_lect = -1;
    int         lect_count = 0;
    int         sclk_rises = 0;
    int         bit_falls = 0;
    bit         check_period = 1'b1;
    logic [7:0] code_q[$];
    logic [5:0] exp_q[$];
    logic [7:0] cur_code = 8'h00;
    logic [4:0] model_temp = 5'd0;
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;
    logic       prev_lect = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // ADC model, scoreboard producer and output monitor
    always @(posedge clock) begin
        #1;
        cyc++;
        if (prev_cs && !adc_cs_n) begin
            cs_fall_cyc = cyc;
            cs_falls++;
            sclk_rises = 0;
            bit_falls  = 0;
            cur_code   = (code_q.size() > 0) ? code_q.pop_front() : 8'h00;
            if (cur_code == 8'hFF) begin
                exp_q.push_back({1'b1, model_temp});
            end else begin
                model_temp = cur_code[7:3];
                exp_q.push_back({1'b0, model_temp});
            end
        end
        if (!prev_sclk && adc_sclk) sclk_rises++;
        if (prev_sclk && !adc_sclk && !adc_cs_n) begin
            bit_falls++;
            if (bit_falls <= 8) adc_dout = cur_code[8-bit_falls];
        end
        if (adc_cs_n) chk("sclk_idle_low", adc_sclk, 1'b0);
        if (lect) begin
            chk("lect_width", prev_lect, 1'b0);
            chk("lect_latency", cyc - cs_fall_cyc, FRAME);
            chk("sclk_rises", sclk_rises, 9);
            chk("cs_high_at_lect", adc_cs_n, 1'b1);
            if (check_period && last_lect >= 0) chk("lect_period", cyc - last_lect, PERIOD);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("temperatura", temperatura, e[4:0]);
                chk("err", err, e[5]);
            end
            lect_count++;
            last_lect = cyc;
        end
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
        prev_lect = lect;
    end

    task automatic wait_lects(input int n);
        int i;
        for (i = 0; i < 4 * PERIOD; i++) begin
            @(posedge clock);
            #2;
            if (lect_count >= n) break;
        end
        chk("lect_timeout", lect_count >= n, 1'b1);
    endtask

    task automatic wait_cs_low();
        int i;
        for (i = 0; i < 2 * PERIOD; i++) begin
            @(posedge clock);
            #2;
            if (!adc_cs_n) break;
        end
        chk("cs_fall_timeout", adc_cs_n, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        en_m1    = 1'b0;
        adc_dout = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_cs_n", adc_cs_n, 1'b1);
        chk("rst_sclk", adc_sclk, 1'b0);
        reset = 1'b0;

        // Released but disabled: everything stays idle
        repeat (60) @(posedge clock);
        #2;
        chk("idle_cs_n", adc_cs_n, 1'b1);
        chk("idle_sclk", adc_sclk, 1'b0);
        chk("idle_temp", temperatura, 5'd0);
        chk("idle_err", err, 1'b0);
        chk("idle_lect", lect, 1'b0);
        chk("idle_no_lect", lect_count, 0);

        // Single frame 0x50 -> 10 C; cs falls on the first enabled edge
        code_q.push_back(8'h50);
        en_m1 = 1'b1;
        @(posedge clock);
        #2;
        chk("cs_falls_first_edge", adc_cs_n, 1'b0);
        wait_lects(1);

        // Back-to-back codes at the nominal period
        code_q.push_back(8'hA0);
        code_q.push_back(8'hC8);
        code_q.push_back(8'hE0);
        code_q.push_back(8'hF8);
        wait_lects(5);
        chk("temp_after_F8", temperatura, 5'd31);

        // Open-sensor code holds the reading and flags err
        code_q.push_back(8'hA0);
        code_q.push_back(8'hFF);
        code_q.push_back(8'h08);
        wait_lects(7);
        chk("ff_hold_temp", temperatura, 5'd20);
        chk("ff_err", err, 1'b1);
        wait_lects(8);
        chk("recover_temp", temperatura, 5'd1);
        chk("recover_err", err, 1'b0);

        // Drop enable mid-frame: the frame still completes
        code_q.push_back(8'h68);
        wait_cs_low();
        repeat (CLK_DIV + 8 * CLK_DIV + 2) @(posedge clock);
        en_m1 = 1'b0;
        wait_lects(9);
        chk("drop_temp", temperatura, 5'd13);
        check_period = 1'b0;
        repeat (3 * PERIOD) @(posedge clock);
        #2;
        chk("drop_idle_cs", adc_cs_n, 1'b1);
        chk("drop_no_frame", cs_falls, 9);
        chk("drop_one_lect", lect_count, 9);

        // Asynchronous reset in the middle of a shift
        code_q.push_back(8'h90);
        en_m1 = 1'b1;
        wait_cs_low();
        repeat (40) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_cs_n", adc_cs_n, 1'b1);
        chk("mid_rst_sclk", adc_sclk, 1'b0);
        chk("mid_rst_temp", temperatura, 5'd0);
        chk("mid_rst_lect", lect, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        exp_q.delete();
        model_temp = 5'd0;
        code_q.push_back(8'h78);
        #29;
        reset = 1'b0;
        chk("rst_no_lect", lect_count, 10 - 1);
        wait_lects(10);
        chk("post_rst_temp", temperatura, 5'd15);
        chk("post_rst_err", err, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        en_m1 = 1'b0;
        repeat (5) @(posedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
